// File: rtl/voice_mixer.sv
// Per-voice gain, frame accumulation, then scale/saturate to one DAC sample per frame.
// Define MIXER_GAIN_EN to build the per-voice gain register file; otherwise every voice is unity.
module voice_mixer #(
  parameter int NUM_VOICES = 8,
  parameter int SHIFT      = 3,
  parameter int ACC_W      = 28
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_sample,
  input  logic [7:0]  i_voice_index,
  input  logic [1:0]  i_pipeline_state,
  input  logic        i_gain_wr,
  input  logic [7:0]  i_gain_voice,
  input  logic [7:0]  i_gain,
  output logic [15:0] o_mix,
  output logic [15:0] o_dac,
  output logic        o_valid,
  output logic        o_clip
);
  localparam int         VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [8:0] NV9    = 9'(NUM_VOICES);
  localparam logic [7:0] LAST   = 8'(NUM_VOICES - 1);

  logic               capture;
  logic signed [17:0] prod;

  assign capture = (i_pipeline_state == 2'd2) && ({1'b0, i_voice_index} < NV9);

`ifdef MIXER_GAIN_EN
  logic [7:0]         gain_q [NUM_VOICES];
  logic [7:0]         gain_d [NUM_VOICES];
  logic [7:0]         gain_rd;
  logic signed [24:0] prod_full;

  always_comb begin
    gain_d = gain_q;
    if (i_gain_wr && ({1'b0, i_gain_voice} < NV9))
      gain_d[i_gain_voice[VIDX_W-1:0]] = i_gain;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_VOICES; i++) gain_q[i] <= 8'd128;
    end else begin
      gain_q <= gain_d;
    end
  end

  // Reads the registered gain, so a write on the capture edge lands for the next frame.
  assign gain_rd   = gain_q[i_voice_index[VIDX_W-1:0]];
  assign prod_full = $signed({{9{i_sample[15]}}, i_sample}) * $signed({17'd0, gain_rd});
  assign prod      = 18'(prod_full >>> 7);
`else
  logic unused_gain;
  assign unused_gain = ^{i_gain_wr, i_gain_voice, i_gain};
  assign prod        = {{2{i_sample[15]}}, i_sample};
`endif

  logic                    s1_vld_q, s1_vld_d;
  logic signed [17:0]      s1_prod_q, s1_prod_d;
  logic [7:0]              s1_tag_q, s1_tag_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    active_q, active_d;
  logic                    done_q, done_d;
  logic [15:0]             mix_q, mix_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;
  logic signed [ACC_W-1:0] scaled;
  logic                    sat_hi, sat_lo;

  assign scaled = acc_q >>> SHIFT;
  assign sat_hi = !scaled[ACC_W-1] && (|scaled[ACC_W-2:15]);
  assign sat_lo =  scaled[ACC_W-1] && !(&scaled[ACC_W-2:15]);

  always_comb begin
    s1_vld_d  = capture;
    s1_prod_d = s1_prod_q;
    s1_tag_d  = s1_tag_q;
    acc_d     = acc_q;
    active_d  = active_q;
    done_d    = 1'b0;
    mix_d     = mix_q;
    valid_d   = done_q;
    clip_d    = clip_q;

    if (capture) begin
      s1_prod_d = prod;
      s1_tag_d  = i_voice_index;
    end

    // Voice 0 always (re)starts a frame; others only count inside an active frame.
    if (s1_vld_q) begin
      if (s1_tag_q == 8'd0) begin
        acc_d    = ACC_W'(s1_prod_q);
        active_d = 1'b1;
      end else if (active_q) begin
        acc_d = acc_q + ACC_W'(s1_prod_q);
        if (s1_tag_q == LAST) begin
          done_d   = 1'b1;
          active_d = 1'b0;
        end
      end
    end

    if (done_q) begin
      if (sat_hi)      mix_d = 16'h7FFF;
      else if (sat_lo) mix_d = 16'h8000;
      else             mix_d = scaled[15:0];
      clip_d = clip_q | sat_hi | sat_lo;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      s1_tag_q  <= '0;
      acc_q     <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_prod_q <= s1_prod_d;
      s1_tag_q  <= s1_tag_d;
      acc_q     <= acc_d;
      active_q  <= active_d;
      done_q    <= done_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
    end
  end

  assign o_mix   = mix_q;
  assign o_dac   = mix_q ^ 16'h8000;
  assign o_valid = valid_q;
  assign o_clip  = clip_q;
endmodule
